// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial sequence path (transmitter and detector).
// Contents:
//   state_e         - transmitter FSM states
//   DEF_*           - default transmitter parameters
//   DET_PATTERN     - pattern the detector looks for; also the canonical test frame
package seq_tx_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_RPT_W      = 4;

    localparam logic [3:0] DET_PATTERN = 4'b0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage : seq_tx_pkg

// File: rtl/down_counter.sv
// Loadable down-counter with a zero flag. It never wraps, so a decrement
// request at zero is ignored. A load takes priority over a decrement.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (count clears to 0)
//   load_i      - load load_val_i this edge
//   load_val_i  - value to load
//   dec_i       - decrement request (ignored at zero)
//   zero_o      - count is zero
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign zero_o = (count_q == '0);

    always_comb begin
        // NOTE: default first so every path assigns count_d; no latch is inferred.
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : down_counter

// File: rtl/seq_tx.sv
// Serial pattern transmitter. On an accepted start it captures a WIDTH-bit
// pattern and a repeat count, then shifts the pattern out MSB-first, one bit
// per clock, sending repeat_cnt+1 frames with GAP_CYCLES idle cycles between.
// Ports:
//   clock       - clock, rising edge
//   reset       - asynchronous active-low reset
//   start       - send request, sampled only in IDLE
//   data        - pattern, captured on accept
//   repeat_cnt  - extra frame count, captured on accept
//   out         - registered serial data, 0 when no bit is being sent
//   out_valid   - high on cycles carrying a frame bit
//   busy        - high from accept until the last bit completes
//   done        - one-cycle pulse after the last bit of the last frame
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int RPT_W      = DEF_RPT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [RPT_W-1:0] repeat_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH);
    // +1 keeps the width at least 1 when GAP_CYCLES is 1.
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   pat_q;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               bit_zero, gap_zero, frm_zero;
    logic               accept, frame_end, gap_end;

    assign accept    = (state_q == IDLE)  && start;
    assign frame_end = (state_q == SHIFT) && bit_zero;
    assign gap_end   = (state_q == GAP)   && gap_zero;

    // Bits remaining in the current frame after the one on the line.
    down_counter #(.W(BIT_W)) u_bit_cnt (
        .clk        (clock),
        .rst_n      (reset),
        .load_i     (accept || gap_end),
        .load_val_i (BIT_W'(WIDTH - 1)),
        .dec_i      (state_q == SHIFT),
        .zero_o     (bit_zero)
    );

    // Idle cycles left in the current gap.
    down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk        (clock),
        .rst_n      (reset),
        .load_i     (frame_end && !frm_zero),
        .load_val_i (GAP_W'(GAP_CYCLES - 1)),
        .dec_i      (state_q == GAP),
        .zero_o     (gap_zero)
    );

    // Frames still to send after the current one.
    down_counter #(.W(RPT_W)) u_frm_cnt (
        .clk        (clock),
        .rst_n      (reset),
        .load_i     (accept),
        .load_val_i (repeat_cnt),
        .dec_i      (frame_end),
        .zero_o     (frm_zero)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (bit_zero) state_d = frm_zero ? IDLE : GAP;
            GAP:     if (gap_zero) state_d = SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Shift register contents for the next cycle. Repeated frames reload from
    // the captured pattern so later changes on data do not leak in.
    always_comb begin
        shift_d = shift_q;
        if (accept) begin
            shift_d = data;
        end else if ((state_q == SHIFT) && !bit_zero) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end else if (gap_end) begin
            shift_d = pat_q;
        end
    end

    // Output logic: values the output registers take at the coming edge.
    // The MSB of the next shift contents is the bit presented next cycle.
    always_comb begin
        out_valid_d = (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
        done_d      = frame_end && frm_zero;
        out_d       = out_valid_d && shift_d[WIDTH-1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q     <= '0;
            pat_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            if (accept) begin
                pat_q   <= data;
            end
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : seq_tx

// File: tb/tb_seq_tx.sv
// Directed testbench for seq_tx with WIDTH=4, GAP_CYCLES=2, RPT_W=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Cycle c of a scenario is the cycle following edge k+c, where k is the
// edge that accepts start.
module tb_seq_tx;
    import seq_tx_pkg::*;

    localparam int WIDTH      = 4;
    localparam int GAP_CYCLES = 2;
    localparam int RPT_W      = 4;

    logic             clock      = 1'b0;
    logic             reset      = 1'b0;
    logic             start      = 1'b0;
    logic [WIDTH-1:0] data       = '0;
    logic [RPT_W-1:0] repeat_cnt = '0;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    seq_tx #(
        .WIDTH      (WIDTH),
        .GAP_CYCLES (GAP_CYCLES),
        .RPT_W      (RPT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .data       (data),
        .repeat_cnt (repeat_cnt),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        #2;
        n_cmp++;
        if ({out, out_valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold out,valid,busy,done got %b want 0000",
                     {out, out_valid, busy, done});
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if ({out, out_valid, busy, done} !== 4'b0000) begin
                n_err++;
                $display("FAIL idle c=%0d out,valid,busy,done got %b want 0000",
                         c, {out, out_valid, busy, done});
            end
        end
    endtask

    task automatic test_single();
        logic [5:0]       e_out  = 6'b010000;
        logic [5:0]       e_val  = 6'b111100;
        logic [5:0]       e_busy = 6'b111100;
        logic [5:0]       e_done = 6'b000010;
        logic [WIDTH-1:0] got    = '0;
        data       = 4'b0100;
        repeat_cnt = 4'd0;
        start      = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) start = 1'b0;
            n_cmp++;
            if ({out, out_valid, busy, done} !==
                {e_out[5-c], e_val[5-c], e_busy[5-c], e_done[5-c]}) begin
                n_err++;
                $display("FAIL single c=%0d out,valid,busy,done got %b want %b",
                         c, {out, out_valid, busy, done},
                         {e_out[5-c], e_val[5-c], e_busy[5-c], e_done[5-c]});
            end
            if (out_valid) got = {got[WIDTH-2:0], out};
        end
        n_cmp++;
        if (got !== DET_PATTERN) begin
            n_err++;
            $display("FAIL single_pattern got %b want %b", got, DET_PATTERN);
        end
    endtask

    // Three frames of 1011; data and repeat_cnt are changed in the first gap
    // and a start is raised mid-frame, none of which may affect the output.
    task automatic test_repeat();
        logic [19:0] e_out  = 20'b10110010110010110000;
        logic [19:0] e_val  = 20'b11110011110011110000;
        logic [19:0] e_busy = 20'b11111111111111110000;
        logic [19:0] e_done = 20'b00000000000000001000;
        int busy_n = 0;
        int done_n = 0;
        data       = 4'b1011;
        repeat_cnt = 4'd2;
        start      = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            n_cmp++;
            if ({out, out_valid, busy, done} !==
                {e_out[19-c], e_val[19-c], e_busy[19-c], e_done[19-c]}) begin
                n_err++;
                $display("FAIL repeat c=%0d out,valid,busy,done got %b want %b",
                         c, {out, out_valid, busy, done},
                         {e_out[19-c], e_val[19-c], e_busy[19-c], e_done[19-c]});
            end
            if (busy) busy_n++;
            if (done) done_n++;
            if (c == 0) start = 1'b0;
            if (c == 4) begin
                data       = 4'b1111;
                repeat_cnt = 4'd0;
            end
            if (c == 7) start = 1'b1;
            if (c == 8) start = 1'b0;
        end
        n_cmp++;
        if (busy_n != 16) begin
            n_err++;
            $display("FAIL repeat_busy_cycles got %0d want 16", busy_n);
        end
        n_cmp++;
        if (done_n != 1) begin
            n_err++;
            $display("FAIL repeat_done_pulses got %0d want 1", done_n);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] e_out  = 6'b011000;
        logic [5:0] e_val  = 6'b111100;
        logic [5:0] e_busy = 6'b111100;
        logic [5:0] e_done = 6'b000010;
        data       = 4'b1110;
        repeat_cnt = 4'd1;
        start      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (c == 0) start = 1'b0;
            n_cmp++;
            if ({out, out_valid, busy, done} !== 4'b1110) begin
                n_err++;
                $display("FAIL pre_abort c=%0d out,valid,busy,done got %b want 1110",
                         c, {out, out_valid, busy, done});
            end
        end
        // Mid-cycle during bit 2: outputs must clear without waiting for an edge.
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({out, out_valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_clear out,valid,busy,done got %b want 0000",
                     {out, out_valid, busy, done});
        end
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if ({out, out_valid, busy, done} !== 4'b0000) begin
                n_err++;
                $display("FAIL in_reset c=%0d out,valid,busy,done got %b want 0000",
                         c, {out, out_valid, busy, done});
            end
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if ({out, out_valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL post_release out,valid,busy,done got %b want 0000",
                     {out, out_valid, busy, done});
        end
        data       = 4'b0110;
        repeat_cnt = 4'd0;
        start      = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) start = 1'b0;
            n_cmp++;
            if ({out, out_valid, busy, done} !==
                {e_out[5-c], e_val[5-c], e_busy[5-c], e_done[5-c]}) begin
                n_err++;
                $display("FAIL after_reset c=%0d out,valid,busy,done got %b want %b",
                         c, {out, out_valid, busy, done},
                         {e_out[5-c], e_val[5-c], e_busy[5-c], e_done[5-c]});
            end
        end
    endtask

    // start held high: each done cycle is also the one idle cycle between frames.
    task automatic test_back_to_back();
        logic [15:0] e_out  = 16'b1001010010100100;
        logic [15:0] e_val  = 16'b1111011110111100;
        logic [15:0] e_busy = 16'b1111011110111100;
        logic [15:0] e_done = 16'b0000100001000010;
        int done_n = 0;
        data       = 4'b1001;
        repeat_cnt = 4'd0;
        start      = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step();
            n_cmp++;
            if ({out, out_valid, busy, done} !==
                {e_out[15-c], e_val[15-c], e_busy[15-c], e_done[15-c]}) begin
                n_err++;
                $display("FAIL b2b c=%0d out,valid,busy,done got %b want %b",
                         c, {out, out_valid, busy, done},
                         {e_out[15-c], e_val[15-c], e_busy[15-c], e_done[15-c]});
            end
            if (done) done_n++;
            if (c == 14) start = 1'b0;
        end
        n_cmp++;
        if (done_n != 3) begin
            n_err++;
            $display("FAIL b2b_done_pulses got %0d want 3", done_n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_tx

// File: doc/seq_tx.md
# seq_tx

Serial pattern transmitter, the sending side of the serial sequence-detector path. It accepts a parallel WIDTH-bit pattern with a start pulse and shifts it out MSB-first on a one-bit line, one bit per clock. It can optionally repeat the frame with idle gaps between copies. Its `out` line drives the detector's `in` directly, so it serves both as the on-chip stimulus source and as a standalone serializer.

## Interface
- `WIDTH`, default 4: bits per frame, at least 2.
- `GAP_CYCLES`, default 2: idle cycles between repeated frames, at least 1.
- `RPT_W`, default 4: width of the repeat count.
- `clock`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low. Asserting it (0) clears all state immediately; deassertion is synchronous to `clock` at the system level.
- `start`, input, 1: request to send; sampled only in IDLE.
- `data`, input, WIDTH: pattern; captured on an accepted start.
- `repeat_cnt`, input, RPT_W: number of extra copies; captured on an accepted start. Total frames = `repeat_cnt` + 1.
- `out`, output, 1: serial data. Registered; 0 whenever no bit is being sent.
- `out_valid`, output, 1: high exactly during cycles carrying a frame bit.
- `busy`, output, 1: high from accept until the final bit completes.
- `done`, output, 1: one-cycle pulse after the last bit of the last frame.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `start`=1 at an edge → SHIFT. At the same edge, load the shift register with `data`, load the frame counter with `repeat_cnt`, load the bit counter with WIDTH-1, and drive `out`=`data[WIDTH-1]`, `out_valid`=1, `busy`=1.
  - `start`=0 → stay in IDLE, with `out`=0 and `out_valid`=0.
- SHIFT:
  - Each edge shifts left and presents the next bit; the bit counter decrements.
  - At an edge where the bit counter is 0:
    - If the frame counter is nonzero, go to GAP: decrement the frame counter, load the gap counter with GAP_CYCLES-1, and drive `out`=0, `out_valid`=0. `busy` stays 1.
    - Otherwise go to IDLE: `busy`=0, `done`=1, `out`=0, `out_valid`=0.
- GAP:
  - The gap counter decrements each edge.
  - At an edge where the gap counter is 0, go to SHIFT: reload the shift register from the captured pattern (not the live `data`), reload the bit counter to WIDTH-1, and present the MSB.
- `start` in SHIFT or GAP is ignored. No queuing, no error flag.
- `data` and `repeat_cnt` may change freely after accept; only the captured copies are used.
- Counters never wrap: every decrement is guarded by its zero test.

## Timing
- Reset values: `out`=0, `out_valid`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- Start accepted at edge k: the MSB is visible from edge k. Bit i (MSB = 0) is valid in the cycle following edge k+i.
- Frame length: exactly WIDTH cycles of `out_valid`=1, with no bubbles.
- Between repeated frames: exactly GAP_CYCLES cycles with `out_valid`=0.
- `done` rises at edge k + (R+1)·WIDTH + R·GAP_CYCLES, where R is the captured repeat count, and falls on the next edge.
- Back-to-back: `start` high during the `done` cycle is accepted at the next edge, because the state is already IDLE. This gives a 1-cycle gap, with `out`=0 for that cycle.
- `reset` asserted mid-frame or mid-gap: all outputs go to their reset values asynchronously. No `done` is issued, and the frame is abandoned.
- `start` and `reset` both active: reset wins.

## Structure
- Shared package `seq_tx_pkg`:
  - the state enum (IDLE, SHIFT, GAP);
  - default WIDTH, GAP_CYCLES and RPT_W constants;
  - the detector's target pattern constant `DET_PATTERN` = 4'b0100, so the detector and this block share one definition.
- Natural sub-module: `down_counter`, a parameterized loadable down-counter with a zero flag. It is instantiated for the bit, gap and frame counters.
- The shift register and FSM stay in `seq_tx`.

## Test plan
- Reset, then idle 5 cycles with `start`=0 → `out`=0, `out_valid`=0, `busy`=0, `done`=0 throughout.
- `data`=4'b0100, `repeat_cnt`=0, `start` pulsed one cycle:
  - `out` = 0,1,0,0 on 4 consecutive cycles, with `out_valid`=1 on those cycles only;
  - `done`=1 on the 5th cycle;
  - with the detector connected, the detector output goes to 1 one cycle after the last bit.
- `data`=4'b1011, `repeat_cnt`=2 → three frames of 1,0,1,1, each separated by exactly 2 `out_valid`=0 cycles. `busy` is high for 16 cycles. There is one `done` pulse.
- `data` changed to 4'b1111 during the first gap of the previous scenario → frames 2 and 3 are still 1,0,1,1. A `start` raised mid-frame is ignored, with no extra frame.
- `reset` dropped to 0 during bit 2 of a frame → `out`, `out_valid` and `busy` go to 0 immediately, with no `done`. After release, a new start sends the full frame correctly.
- `start` held high continuously with `repeat_cnt`=0 → frames repeat with exactly 1 idle cycle between them, and `done` pulses once per frame.
